// File: rtl/test_engine_nic_flit_sequencer.sv
// test_engine_nic_flit_sequencer: credit-gated five-flit packet sequencer.
// Each PE done strobe emits header + four data-word flits, stalling whenever router credits run out.
module test_engine_nic_flit_sequencer #(
  parameter int CREDIT_DEPTH = 5,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done_strobe_din,
  input  logic       credit_in_din,
  output logic [2:0] output_selector_dout,
  output logic       zero_credits_dout,
  output logic       busy_dout,
  output logic       protocol_error_dout
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(CREDIT_DEPTH);
  state_t r_state;
  logic [2:0] r_idx;
  logic [CREDIT_WIDTH-1:0] r_cnt;
  logic w_issue, w_sat;
  assign w_issue = r_state == SEND && r_cnt != '0;
  // a credit arriving at a full counter is only an overflow when no flit consumes one this edge
  assign w_sat = credit_in_din && !w_issue && r_cnt == FULL;
  assign zero_credits_dout = r_cnt == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_idx <= 3'd0;
      r_cnt <= FULL;
      output_selector_dout <= 3'd0;
      busy_dout <= 1'b0;
      protocol_error_dout <= 1'b0;
    end else begin
      output_selector_dout <= w_issue ? 3'd5 - r_idx : 3'd0;
      if (!w_sat) r_cnt <= r_cnt - CREDIT_WIDTH'(w_issue) + CREDIT_WIDTH'(credit_in_din);
      if (w_sat || (done_strobe_din && busy_dout)) protocol_error_dout <= 1'b1;
      if (r_state == IDLE && done_strobe_din) begin
        r_state <= SEND;
        r_idx <= 3'd0;
        busy_dout <= 1'b1;
      end else if (w_issue) begin
        r_state <= r_idx == 3'd4 ? IDLE : SEND;
        r_idx <= r_idx == 3'd4 ? 3'd0 : r_idx + 3'd1;
        busy_dout <= r_idx != 3'd4;
      end
    end
endmodule
